// File: rtl/layer_compositor.sv
// layer_compositor: two-stage priority compositor for N_LAYERS sprite/background
// layers with per-frame player-vs-obstacle collision accumulation.
// Optional feature macro: COMPOSITOR_COLORKEY_EN (colour-keyed transparency
// against KEY for every layer except the background).
module layer_compositor #(
   parameter int               N_LAYERS = 8,
   parameter int               RGB_W    = 3,
   parameter logic [RGB_W-1:0] KEY      = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      pixel_tick,
   input  logic                      video_on,
   input  logic                      frame_start,
   input  logic [N_LAYERS-1:0]       on_objs,
   input  logic [N_LAYERS*RGB_W-1:0] rgb_objs,
   output logic [RGB_W-1:0]          rgb_out,
   output logic                      pix_hit,
   output logic [3:0]                layer_id,
   output logic [N_LAYERS-1:0]       collision_vec,
   output logic                      collision_pulse
);

`ifdef COMPOSITOR_COLORKEY_EN
   localparam logic KEY_EN = 1'b1;
`else
   localparam logic KEY_EN = 1'b0;
`endif

   // Stage-1 registers
   logic [N_LAYERS-1:0]       s1_on;
   logic [N_LAYERS*RGB_W-1:0] s1_rgb;
   logic                      s1_vid;
   logic                      s1_fs;

   // Stage-2 combinational results
   logic [N_LAYERS-1:0] key_hit;
   logic [N_LAYERS-1:0] eff;
   logic [N_LAYERS-1:0] ovl;
   logic                win_found;
   logic [3:0]          win_id;
   logic [RGB_W-1:0]    win_rgb;

   // Per-frame overlap accumulator
   logic [N_LAYERS-1:0] acc;

   // Capture the incoming layer data on every advancing pixel tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_on  <= '0;
         s1_rgb <= '0;
         s1_vid <= 1'b0;
         s1_fs  <= 1'b0;
      end else if (pixel_tick) begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, so the stages shift together instead of racing.
         s1_on  <= on_objs;
         s1_rgb <= rgb_objs;
         s1_vid <= video_on;
         s1_fs  <= frame_start;
      end
   end

   // Effective coverage: colour-keyed layers drop out; the background never keys.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      key_hit = '0;
      for (int i = 0; i < N_LAYERS - 1; i++) begin
         key_hit[i] = (s1_rgb[i*RGB_W +: RGB_W] == KEY);
      end
      eff = s1_on & ~(key_hit & {N_LAYERS{KEY_EN}});
   end

   // Priority select: descending scan so the lowest covered index wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_rgb   = '0;
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
         if (eff[i]) begin
            win_found = 1'b1;
            win_id    = 4'(i);
            win_rgb   = s1_rgb[i*RGB_W +: RGB_W];
         end
      end
   end

   // Player overlap terms for this pixel; layer 0 and the background excluded.
   always_comb begin
      ovl = '0;
      for (int i = 1; i < N_LAYERS - 1; i++) begin
         ovl[i] = eff[0] & eff[i] & s1_vid;
      end
   end

   // Output pixel register; blanked outside the visible area.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rgb_out  <= '0;
         pix_hit  <= 1'b0;
         layer_id <= '0;
      end else if (pixel_tick) begin
         if (s1_vid && win_found) begin
            rgb_out  <= win_rgb;
            pix_hit  <= 1'b1;
            layer_id <= win_id;
         end else begin
            rgb_out  <= '0;
            pix_hit  <= 1'b0;
            layer_id <= '0;
         end
      end
   end

   // Collision accumulation; the frame-start pixel opens the new frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc           <= '0;
         collision_vec <= '0;
      end else if (pixel_tick) begin
         if (s1_fs) begin
            collision_vec <= acc;
            acc           <= ovl;
         end else begin
            acc <= acc | ovl;
         end
      end
   end

   // Single-clk strobe whenever a nonzero frame result is latched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         collision_pulse <= 1'b0;
      end else begin
         collision_pulse <= pixel_tick & s1_fs & (acc != '0);
      end
   end

endmodule
